mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory-access stage of the 5-stage pipeline. It sits between the ex_mem register and the mem_wb register. It executes loads and stores over a single-outstanding req/ack data bus and holds the pipeline with stallreq while an access is in flight. Non-memory instructions pass through combinationally to the mem_wb inputs.

Parameters:
ADDR_W, 32, data-bus address width
DATA_W, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush from control
ex_wd  in  5  destination register address
ex_wreg  in  1  register write enable
ex_wdata  in  32  ALU result
ex_memop  in  4  0=none,1=LB,2=LBU,3=LH,4=LHU,5=LW,8=SB,9=SH,10=SW; all other codes are treated as none
ex_addr  in  ADDR_W  effective address
ex_sdata  in  32  store data (reg2)
mem_wd  out  5  to mem_wb
mem_wreg  out  1  to mem_wb
mem_wdata  out  32  to mem_wb
stallreq  out  1  stall request to the stall controller (holds stages 0..3)
bus_req  out  1  access request, registered
bus_we  out  1  1=store, registered
bus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}), registered
bus_sel  out  4  byte enables, registered
bus_wdata  out  32  store data, registered
bus_ack  in  1  access complete; rdata valid in the same cycle
bus_rdata  in  32  read data
excp_misalign  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (synchronous): state=IDLE; bus_req, bus_we, bus_sel, bus_addr, bus_wdata, the load data register and excp_misalign all 0.
- While rst=1, the combinational outputs are forced: mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - Non-memory op: mem_* = ex_* combinationally; stallreq=0.
  - Memory op: stallreq=1 and mem_wreg=0. On the clock edge, bus_* are loaded and the FSM moves to BUSY.
- BUSY:
  - bus_req=1 with all bus_* held stable; stallreq=1; mem_wreg=0.
  - On bus_ack: capture bus_rdata, bus_req<=0, go to DONE.
  - If flush=1 (with or without ack): go to DRAIN, or to IDLE if ack arrives in the same cycle. Captured data is discarded.
- DONE:
  - stallreq=0; mem_wd=ex_wd.
  - Load: mem_wreg=ex_wreg, mem_wdata = extended load data.
  - Store: mem_wreg=0.
  - Next state is IDLE unconditionally. The pipeline advances on this edge.
- DRAIN: bus_req held at 1 until bus_ack (the bus forbids withdrawing a request); stallreq=1; mem_wreg=0. On ack: bus_req<=0, go to IDLE, data dropped.
- flush in IDLE or DONE: no effect on the FSM. mem_wb performs the squash.
- Minimum latency: 3 cycles (IDLE, BUSY, DONE), i.e. 2 stall cycles when ack arrives in the first BUSY cycle. Each extra wait cycle adds one stall cycle.
- Byte lanes are big-endian. For addr[1:0]=00/01/10/11:
  - Byte access: sel = 1000/0100/0010/0001; load byte comes from lane [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword: addr[1]=0 gives sel 1100 and lane [31:16]; addr[1]=1 gives sel 0011 and lane [15:0].
  - Word: sel 1111.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Store data is replicated across lanes: SB {4{sdata[7:0]}}, SH {2{sdata[15:0]}}, SW sdata.
- A load or store is never issued twice: the return to IDLE happens exactly on the edge where the pipeline advances.

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - No bus access is made and stallreq=0.
  - mem_wreg=0 and excp_misalign=1 for that cycle (combinational).
- Undefined: excp_misalign is tied to 0 and the low address bits are ignored for halfword and word accesses (forced alignment).

Test Plan:
- ADD result 0x12345678 to r3, memop=0 -> mem_wdata=0x12345678, mem_wreg=1 in the same cycle, stallreq=0, bus_req stays 0.
- LB addr 0x100 (00), ack in the first BUSY cycle, rdata 0x80AABBCC -> bus_sel=1000, stallreq high for 2 cycles, DONE mem_wdata=0xFFFFFF80; with LBU the result is 0x00000080.
- SH sdata 0x0000BEEF addr 0x202, ack after 3 wait cycles -> bus_we=1, sel=0011, wdata=0xBEEFBEEF, bus_addr=0x200, 5 stall cycles, mem_wreg=0.
- LW in flight, flush in the 2nd BUSY cycle, ack 2 cycles later -> bus_req held until ack, then IDLE. No write reaches mem_wb, and bus_req never drops before ack.
- rst asserted mid-BUSY -> next cycle: bus_req=0, state IDLE, all outputs 0.
- With MEM_ALIGN_CHECK_EN: LW addr 0x102 -> excp_misalign=1, bus_req=0, stallreq=0. Without the macro: bus_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-access stage: loads/stores over a single-outstanding req/ack bus
//
// Sits between the ex_mem and mem_wb pipeline registers. Non-memory ops pass
// straight through to the mem_wb inputs. Loads and stores hold the pipeline
// with stallreq until the bus acknowledges. A four-state FSM controls this:
// IDLE, BUSY, DONE and DRAIN.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : a misaligned halfword/word access raises excp_misalign and issues no bus access
//   undefined : excp_misalign is tied low and the low address bits are ignored (forced alignment)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           pipeline flush from control
//   ex_wd/ex_wreg   destination register and write enable from ex_mem
//   ex_wdata        ALU result from ex_mem
//   ex_memop        memory op code (0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 8 SB, 9 SH, 10 SW)
//   ex_addr         effective address
//   ex_sdata        store data
//   mem_wd/mem_wreg/mem_wdata  to mem_wb
//   stallreq        holds pipeline stages 0..3
//   bus_req/bus_we/bus_addr/bus_sel/bus_wdata  registered bus request
//   bus_ack/bus_rdata  bus completion; rdata valid with ack
//   excp_misalign   misaligned access flag

module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [3:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_sdata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stallreq,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              excp_misalign
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]        r_state;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_sel;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_ldata;
  logic [3:0]        r_op;
  logic [1:0]        r_off;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misalign;
  logic              w_issue;
  logic [1:0]        w_size;
  logic [3:0]        w_sel;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_lbyte;
  logic [15:0]       w_lhalf;
  logic [DATA_W-1:0] w_ext;

  // ---------------------------------------------------------------------------
  // Decode of the op presented by ex_mem
  // ---------------------------------------------------------------------------
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = SZ_BYTE;
    case (ex_memop)
      4'd1, 4'd2: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
      4'd3, 4'd4: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
      4'd5:       begin w_is_load  = 1'b1; w_size = SZ_WORD; end
      4'd8:       begin w_is_store = 1'b1; w_size = SZ_BYTE; end
      4'd9:       begin w_is_store = 1'b1; w_size = SZ_HALF; end
      4'd10:      begin w_is_store = 1'b1; w_size = SZ_WORD; end
      default:    begin w_is_load  = 1'b0; w_is_store = 1'b0; end
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem &
                      (((w_size == SZ_HALF) & ex_addr[0]) |
                       ((w_size == SZ_WORD) & (ex_addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = w_is_mem & ~w_misalign;

  // Big-endian lanes: byte offset 0 is the most significant lane.
  // Halfword and word decode look only at the bits that matter, which gives
  // forced alignment when the check is compiled out.
  always_comb begin
    w_sel   = 4'b0000;
    w_wdata = '0;
    case (w_size)
      SZ_BYTE: begin
        w_sel   = 4'b1000 >> ex_addr[1:0];
        w_wdata = {4{ex_sdata[7:0]}};
      end
      SZ_HALF: begin
        w_sel   = ex_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{ex_sdata[15:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_wdata = ex_sdata;
      end
    endcase
    if (!w_is_store) w_wdata = '0;
  end

  // ---------------------------------------------------------------------------
  // FSM and registered bus interface
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= 4'b0000;
      r_bus_wdata <= '0;
      r_ldata     <= '0;
      r_op        <= 4'd0;
      r_off       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_wdata;
            r_op        <= ex_memop;
            r_off       <= ex_addr[1:0];
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            // A flush coinciding with ack drops the data and returns directly.
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_ldata <= bus_rdata;
              r_state <= S_DONE;
            end
          end else if (flush) begin
            // The request cannot be withdrawn; wait for ack in DRAIN.
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          // The pipeline advances on this edge, so the op is not re-issued.
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load data extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    case (r_off)
      2'b00:   w_lbyte = r_ldata[31:24];
      2'b01:   w_lbyte = r_ldata[23:16];
      2'b10:   w_lbyte = r_ldata[15:8];
      default: w_lbyte = r_ldata[7:0];
    endcase
    w_lhalf = r_off[1] ? r_ldata[15:0] : r_ldata[31:16];
  end

  always_comb begin
    case (r_op)
      4'd1:    w_ext = {{24{w_lbyte[7]}}, w_lbyte};
      4'd2:    w_ext = {24'd0, w_lbyte};
      4'd3:    w_ext = {{16{w_lhalf[15]}}, w_lhalf};
      4'd4:    w_ext = {16'd0, w_lhalf};
      default: w_ext = r_ldata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wd        = ex_wd;
    mem_wreg      = ex_wreg;
    mem_wdata     = ex_wdata;
    stallreq      = 1'b0;
    excp_misalign = 1'b0;
    if (rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_misalign) begin
            mem_wreg      = 1'b0;
            excp_misalign = 1'b1;
          end else if (w_is_mem) begin
            mem_wreg = 1'b0;
            stallreq = 1'b1;
          end
        end
        S_DONE: begin
          if (r_bus_we) begin
            mem_wreg = 1'b0;
          end else begin
            mem_wdata = w_ext;
          end
        end
        default: begin
          mem_wreg = 1'b0;
          stallreq = 1'b1;
        end
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_sel   = r_bus_sel;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu

module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        excp_misalign;

  int vectors;
  int miscompares;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .excp_misalign(excp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access: IDLE issue, BUSY with 'waits' extra cycles, DONE.
  task automatic xfer(input string tag, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                      input logic [3:0] e_sel, input logic [31:0] e_addr,
                      input logic e_we, input logic [31:0] e_bwdata,
                      input logic e_wreg, input logic [31:0] e_wdata);
    int stalls;
    tick();
    ex_memop = op; ex_addr = addr; ex_sdata = sdata;
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEAD0000;
    @(negedge clk);
    stalls = int'(stallreq);
    chk({tag, "_idle_wreg"}, 32'(mem_wreg), 32'd0);
    chk({tag, "_idle_req"}, 32'(bus_req), 32'd0);
    for (int w = 0; w <= waits; w++) begin
      tick();
      bus_ack   = (w == waits);
      bus_rdata = (w == waits) ? rdata : 32'h0;
      @(negedge clk);
      stalls += int'(stallreq);
      chk({tag, "_busy_req"}, 32'(bus_req), 32'd1);
      chk({tag, "_busy_sel"}, 32'(bus_sel), 32'(e_sel));
      chk({tag, "_busy_addr"}, bus_addr, e_addr);
      chk({tag, "_busy_we"}, 32'(bus_we), 32'(e_we));
      chk({tag, "_busy_wreg"}, 32'(mem_wreg), 32'd0);
      if (e_we) chk({tag, "_busy_wdata"}, bus_wdata, e_bwdata);
    end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    stalls += int'(stallreq);
    chk({tag, "_done_wreg"}, 32'(mem_wreg), 32'(e_wreg));
    if (e_wreg) chk({tag, "_done_wdata"}, mem_wdata, e_wdata);
    chk({tag, "_done_wd"}, 32'(mem_wd), 32'd7);
    chk({tag, "_done_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_stalls"}, 32'(stalls), 32'(waits + 2));
    tick();
    ex_memop = 4'd0; ex_wreg = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; flush = 1'b0;
    ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hA5A5A5A5;
    ex_memop = 4'd0; ex_addr = 32'h0; ex_sdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;

    // Reset: combinational outputs forced low, bus idle
    tick();
    @(negedge clk);
    chk("rst_wd", 32'(mem_wd), 32'd0);
    chk("rst_wreg", 32'(mem_wreg), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_sel", 32'(bus_sel), 32'd0);
    chk("rst_excp", 32'(excp_misalign), 32'd0);

    // Non-memory pass-through
    tick();
    rst = 1'b0;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h12345678; ex_memop = 4'd0;
    @(negedge clk);
    chk("alu_wdata", mem_wdata, 32'h12345678);
    chk("alu_wreg", 32'(mem_wreg), 32'd1);
    chk("alu_wd", 32'(mem_wd), 32'd3);
    chk("alu_stall", 32'(stallreq), 32'd0);
    tick();
    ex_memop = 4'd6;  // unused code behaves as none
    @(negedge clk);
    chk("alu_req", 32'(bus_req), 32'd0);
    chk("op6_wreg", 32'(mem_wreg), 32'd1);
    chk("op6_stall", 32'(stallreq), 32'd0);
    ex_memop = 4'd0; ex_wreg = 1'b0;

    // Loads
    xfer("lb00", 4'd1, 32'h100, 32'h0, 32'h80AABBCC, 0, 4'b1000, 32'h100, 1'b0, 32'h0, 1'b1, 32'hFFFFFF80);
    xfer("lbu00", 4'd2, 32'h100, 32'h0, 32'h80AABBCC, 0, 4'b1000, 32'h100, 1'b0, 32'h0, 1'b1, 32'h00000080);
    xfer("lb01", 4'd1, 32'h101, 32'h0, 32'h00FF0000, 1, 4'b0100, 32'h100, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
    xfer("lb11", 4'd1, 32'h103, 32'h0, 32'h0000007F, 0, 4'b0001, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0000007F);
    xfer("lh10", 4'd3, 32'h102, 32'h0, 32'h1234ABCD, 0, 4'b0011, 32'h100, 1'b0, 32'h0, 1'b1, 32'hFFFFABCD);
    xfer("lhu00", 4'd4, 32'h100, 32'h0, 32'h8765ABCD, 0, 4'b1100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h00008765);
    xfer("lw", 4'd5, 32'h108, 32'h0, 32'h89ABCDEF, 0, 4'b1111, 32'h108, 1'b0, 32'h0, 1'b1, 32'h89ABCDEF);

    // Stores
    xfer("sh", 4'd9, 32'h202, 32'h0000BEEF, 32'h0, 3, 4'b0011, 32'h200, 1'b1, 32'hBEEFBEEF, 1'b0, 32'h0);
    xfer("sb", 4'd8, 32'h203, 32'h1234565A, 32'h0, 0, 4'b0001, 32'h200, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h0);
    xfer("sw", 4'd10, 32'h204, 32'hCAFEF00D, 32'h0, 1, 4'b1111, 32'h204, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);

    // Flush in the 2nd BUSY cycle, ack two cycles later (in DRAIN)
    tick();
    ex_memop = 4'd5; ex_addr = 32'h300; ex_wd = 5'd4; ex_wreg = 1'b1;
    tick();                                   // BUSY 1
    @(negedge clk);
    chk("fl_b1_req", 32'(bus_req), 32'd1);
    tick(); flush = 1'b1;                     // BUSY 2 with flush
    @(negedge clk);
    chk("fl_b2_req", 32'(bus_req), 32'd1);
    chk("fl_b2_wreg", 32'(mem_wreg), 32'd0);
    tick(); flush = 1'b0;                     // DRAIN 1
    @(negedge clk);
    chk("fl_d1_req", 32'(bus_req), 32'd1);
    chk("fl_d1_stall", 32'(stallreq), 32'd1);
    chk("fl_d1_wreg", 32'(mem_wreg), 32'd0);
    tick(); bus_ack = 1'b1; bus_rdata = 32'h11111111;  // DRAIN 2 with ack
    @(negedge clk);
    chk("fl_d2_req", 32'(bus_req), 32'd1);
    chk("fl_d2_wreg", 32'(mem_wreg), 32'd0);
    tick(); bus_ack = 1'b0; bus_rdata = 32'h0;        // back to IDLE
    ex_memop = 4'd0; ex_wreg = 1'b1; ex_wdata = 32'h0000BEAD; ex_wd = 5'd2;
    @(negedge clk);
    chk("fl_idle_req", 32'(bus_req), 32'd0);
    chk("fl_idle_stall", 32'(stallreq), 32'd0);
    chk("fl_idle_wdata", mem_wdata, 32'h0000BEAD);
    ex_wreg = 1'b0;

    // Reset asserted mid-BUSY
    tick();
    ex_memop = 4'd5; ex_addr = 32'h400; ex_wreg = 1'b1;
    tick();                                   // BUSY
    @(negedge clk);
    chk("rb_busy_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_after_req", 32'(bus_req), 32'd0);
    chk("rb_after_wreg", 32'(mem_wreg), 32'd0);
    chk("rb_after_wdata", mem_wdata, 32'd0);
    chk("rb_after_stall", 32'(stallreq), 32'd0);
    tick();
    rst = 1'b0; ex_memop = 4'd0; ex_wreg = 1'b1; ex_wdata = 32'h00C0FFEE; ex_wd = 5'd1;
    @(negedge clk);
    chk("rb_idle_wreg", 32'(mem_wreg), 32'd1);
    chk("rb_idle_wdata", mem_wdata, 32'h00C0FFEE);
    ex_wreg = 1'b0;

    // Misaligned word access
`ifdef MEM_ALIGN_CHECK_EN
    tick();
    ex_memop = 4'd5; ex_addr = 32'h102; ex_wreg = 1'b1;
    @(negedge clk);
    chk("mis_excp", 32'(excp_misalign), 32'd1);
    chk("mis_stall", 32'(stallreq), 32'd0);
    chk("mis_wreg", 32'(mem_wreg), 32'd0);
    tick();
    ex_memop = 4'd0; ex_wreg = 1'b0;
    @(negedge clk);
    chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_excp_clr", 32'(excp_misalign), 32'd0);
`else
    xfer("lw_unal", 4'd5, 32'h102, 32'h0, 32'h11223344, 0, 4'b1111, 32'h100, 1'b0, 32'h0, 1'b1, 32'h11223344);
    chk("unal_excp", 32'(excp_misalign), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
